// File: rtl/led_ctrl_pkg.sv
// Shared field layout, mode encodings and constants for the LED pattern driver.
package led_ctrl_pkg;

  localparam int NUM_LEDS   = 4;
  localparam int CFG_W      = 16;
  localparam int PWM_PERIOD = 15;
  localparam logic [NUM_LEDS-1:0] POS_RESET = 4'b0001;

  localparam int MASK_LSB = 0;
  localparam int MASK_MSB = 3;
  localparam int MODE_LSB = 4;
  localparam int MODE_MSB = 5;
  localparam int RSV_LSB  = 6;
  localparam int RSV_MSB  = 7;
  localparam int DUTY_LSB = 8;
  localparam int DUTY_MSB = 11;
  localparam int RATE_LSB = 12;
  localparam int RATE_MSB = 15;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_CHASE   = 2'b11
  } led_mode_e;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} led_dir_e;

  // Field order mirrors the control word, LSB last.
  typedef struct packed {
    logic [3:0]          rate;
    logic [3:0]          duty;
    logic [1:0]          rsv;
    led_mode_e           mode;
    logic [NUM_LEDS-1:0] mask;
  } led_cfg_t;

  // Reserved bits are captured but never restart the pattern.
  function automatic logic cfg_restart(led_cfg_t a, led_cfg_t b);
    return {a.rate, a.duty, a.mode, a.mask} != {b.rate, b.duty, b.mode, b.mask};
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler to base tick, then a rate-programmable divider to the pattern step tick.
module led_tick_gen #(
  parameter int PRESCALE = 50000,
  parameter int PS_W     = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       restart,
  input  logic [3:0] rate,
  output logic       base_tick,
  output logic       step_tick
);

  logic [PS_W-1:0] pre_cnt;
  logic [3:0]      step_cnt;

  assign base_tick = (pre_cnt == PS_W'(PRESCALE - 1)) && !restart;
  assign step_tick = base_tick && (step_cnt >= rate);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else if (restart) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      pre_cnt <= base_tick ? '0 : pre_cnt + 1'b1;
      if (step_tick)      step_cnt <= '0;
      else if (base_tick) step_cnt <= step_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/apb_led_pattern_driver.sv
// Turns the latched LED control word into PWM-dimmed static, blink, breathe or chase drive.
module apb_led_pattern_driver
  import led_ctrl_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int PS_W     = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [31:0]         ledNumIn,
  output logic [NUM_LEDS-1:0] ledNumOut,
  output logic                ledBusy
);

  led_cfg_t            cfg_in, cfg_q;
  logic                restart, base_tick, step_tick;
  logic [3:0]          pwm_cnt, level;
  logic                phase, pwm_on, breath_on;
  led_dir_e            dir;
  logic [NUM_LEDS-1:0] pos, raw;
  logic                unused_hi;

  assign cfg_in    = led_cfg_t'(ledNumIn[CFG_W-1:0]);
  assign unused_hi = ^ledNumIn[31:CFG_W];
  assign restart   = cfg_restart(cfg_in, cfg_q);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)             cfg_q <= '0;
    else if (cfg_in != cfg_q) cfg_q <= cfg_in;
  end

  led_tick_gen #(.PRESCALE(PRESCALE), .PS_W(PS_W)) u_tick (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .restart   (restart),
    .rate      (cfg_q.rate),
    .base_tick (base_tick),
    .step_tick (step_tick)
  );

  // PWM is free-running so a restart never shifts the dimming phase.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                             pwm_cnt <= '0;
    else if (pwm_cnt == 4'(PWM_PERIOD - 1))   pwm_cnt <= '0;
    else                                      pwm_cnt <= pwm_cnt + 4'd1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      phase <= 1'b1;
      level <= '0;
      dir   <= DIR_UP;
      pos   <= POS_RESET;
    end else if (restart) begin
      phase <= 1'b1;
      level <= '0;
      dir   <= DIR_UP;
      pos   <= POS_RESET;
    end else if (step_tick) begin
      phase <= ~phase;
      pos   <= {pos[NUM_LEDS-2:0], pos[NUM_LEDS-1]};
      // Flip direction as the endpoint is entered so each endpoint lasts one step.
      if (dir == DIR_UP) begin
        level <= level + 4'd1;
        if (level == 4'd14) dir <= DIR_DOWN;
      end else begin
        level <= level - 4'd1;
        if (level == 4'd1) dir <= DIR_UP;
      end
    end
  end

  assign pwm_on    = pwm_cnt < cfg_q.duty;
  assign breath_on = pwm_cnt < level;

  always_comb begin
    raw = '0;
    case (cfg_q.mode)
      MODE_STATIC:  raw = cfg_q.mask & {NUM_LEDS{pwm_on}};
      MODE_BLINK:   raw = cfg_q.mask & {NUM_LEDS{pwm_on & phase}};
      MODE_BREATHE: raw = cfg_q.mask & {NUM_LEDS{breath_on}};
      MODE_CHASE:   raw = cfg_q.mask & pos & {NUM_LEDS{pwm_on}};
      default:      raw = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ledNumOut <= '0;
      ledBusy   <= 1'b0;
    end else begin
      ledNumOut <= raw;
      ledBusy   <= (cfg_q.mode != MODE_STATIC) && (|cfg_q.mask);
    end
  end

endmodule

// File: tb/tb_apb_led_pattern_driver.sv
// Directed and random stimulus against a time-since-restart reference model of the LED driver.
module tb_apb_led_pattern_driver;

  localparam int P = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [31:0] ledNumIn = '0;
  logic [3:0]  ledNumOut;
  logic        ledBusy;

  always #5 PCLK = ~PCLK;

  apb_led_pattern_driver #(.PRESCALE(P), .PS_W(16)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .ledNumIn  (ledNumIn),
    .ledNumOut (ledNumOut),
    .ledBusy   (ledBusy)
  );

  int checks = 0;
  int failures = 0;
  int n = 0;                 // edges since reset release
  int r_edge = 0;            // edge at which the current pattern restarted
  logic [15:0] cfg_m = '0;   // config the DUT holds, per the model

  // Output computed from steps elapsed since restart and the global PWM position.
  function automatic logic [3:0] model_out(logic [15:0] c, int j, int pwm);
    logic [3:0] mask;
    int mode, duty, rate, s, p, lvl;
    bit on;
    mask = c[3:0];
    mode = int'(c[5:4]);
    duty = int'(c[11:8]);
    rate = int'(c[15:12]);
    s    = j / (P * (rate + 1));
    on   = pwm < duty;
    case (mode)
      0: return on ? mask : 4'h0;
      1: return (on && (s % 2 == 0)) ? mask : 4'h0;
      2: begin
        p   = s % 30;
        lvl = (p <= 15) ? p : 30 - p;
        return (pwm < lvl) ? mask : 4'h0;
      end
      default: return on ? (mask & 4'(1 << (s % 4))) : 4'h0;
    endcase
  endfunction

  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic cyc();
    logic [3:0] eo;
    logic       eb;
    eo = model_out(cfg_m, n - r_edge, n % 15);
    eb = (cfg_m[5:4] != 2'b00) && (cfg_m[3:0] != 4'h0);
    if (ledNumIn[15:0] != cfg_m) begin
      if ({ledNumIn[15:8], ledNumIn[5:0]} != {cfg_m[15:8], cfg_m[5:0]}) r_edge = n + 1;
      cfg_m = ledNumIn[15:0];
    end
    @(posedge PCLK);
    n++;
    #1;
    chk("model_out", int'(ledNumOut), int'(eo));
    chk("model_busy", int'(ledBusy), int'(eb));
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) cyc();
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    #1;
    chk("rst_out", int'(ledNumOut), 0);
    chk("rst_busy", int'(ledBusy), 0);
    repeat (3) @(posedge PCLK);
    #2;
    PRESETn = 1'b1;
    n = 0;
    r_edge = 0;
    cfg_m = '0;
  endtask

  initial begin
    int on_cnt, off_cnt;
    do_reset();

    // STATIC full duty: two-cycle latency then steady
    ledNumIn = 32'h0000_0F0F;
    cyc(); chk("static_lat1", int'(ledNumOut), 0);
    cyc(); chk("static_lat2", int'(ledNumOut), 4'hF);
    run(20);
    chk("static_busy", int'(ledBusy), 0);

    // STATIC duty 8: 8 on / 7 off in any 15-cycle window
    ledNumIn = 32'h0000_0805;
    run(5);
    on_cnt = 0; off_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (ledNumOut == 4'h5) on_cnt++;
      if (ledNumOut == 4'h0) off_cnt++;
    end
    chk("duty8_on", on_cnt, 8);
    chk("duty8_off", off_cnt, 7);

    // BLINK rate 0, then ignored/reserved bit changes must not disturb it
    ledNumIn = 32'h0000_0F13;
    cyc();
    run(3); chk("blink_first_on", int'(ledNumOut), 4'h3);
    run(4); chk("blink_then_off", int'(ledNumOut), 4'h0);
    chk("blink_busy", int'(ledBusy), 1);
    run(13);
    ledNumIn = 32'hA5A5_0F13; run(9);
    ledNumIn = 32'hA5A5_0FD3; run(11);
    ledNumIn = 32'h0000_0F53; run(10);

    // CHASE full mask, then mask change restarts at pos 0001
    ledNumIn = 32'h0000_0F3F;
    run(30);
    ledNumIn = 32'h0000_0F3A;
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("chase_masked_step", int'(ledNumOut), 0);
    end
    cyc(); chk("chase_second_step", int'(ledNumOut), 4'h2);
    run(20);

    // BREATHE rate 1: dark at start, full at step 15, reset mid-ramp
    ledNumIn = 32'h0000_1F2F;
    cyc();
    for (int i = 0; i < 6; i++) begin
      cyc(); chk("breathe_start", int'(ledNumOut), 0);
    end
    run(115); chk("breathe_peak", int'(ledNumOut), 4'hF);
    run(30);
    do_reset();
    cyc();
    for (int i = 0; i < 6; i++) begin
      cyc(); chk("breathe_restart", int'(ledNumOut), 0);
    end
    run(140);

    // mask 0 in each timed mode
    ledNumIn = 32'h0000_0F10; run(20);
    ledNumIn = 32'h0000_0F20; run(20);
    ledNumIn = 32'h0000_0F30; run(20);

    // random configurations with random hold times
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0)
        ledNumIn = {16'($urandom), ledNumIn[15:8], 2'($urandom), ledNumIn[5:0]};
      else
        ledNumIn = $urandom;
      run($urandom_range(1, 80));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
